// File: rtl/led_effect_pkg.sv
// Shared types and constants for the LED effect driver: effect modes,
// register map addresses and the reset value of the DUTY register.
package led_effect_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_CHASE = 2'b11
  } mode_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [7:0] DUTY_RESET = 8'h80;

endpackage

// File: rtl/led_tick_gen.sv
// Effect tick prescaler: counts 0..period-1 and pulses tick_o on the last count.
// A period of zero behaves as one, so the tick fires every cycle.
module led_tick_gen #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                clear_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] periodEff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // A clear in the same cycle as a tick still forces the count back to zero.
  always_comb begin
    periodEff = (period_i == '0) ? PERIOD_W'(1) : period_i;
    tick_o    = (count_q == periodEff - PERIOD_W'(1));
    count_d   = count_q + PERIOD_W'(1);
    if (clear_i || tick_o) count_d = '0;
  end

endmodule

// File: rtl/led_effect_driver.sv
// LED effect stage behind the LED PIO, with its own Avalon-MM config slave.
// Define LED_BREATHE_EN to make PWM mode ramp its duty up and down as a triangle.
module led_effect_driver
  import led_effect_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int PERIOD_W     = 26,
  parameter int PERIOD_RESET = 25000000,
  parameter int DUTY_W       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_req,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic                read_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  logic                enable_q, enable_d;
  mode_e               mode_q, mode_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                phase_q, phase_d;
  logic [DUTY_W-1:0]   pwmCnt_q, pwmCnt_d;
  logic [NUM_LEDS-1:0] chasePos_q, chasePos_d;
  logic [NUM_LEDS-1:0] ledOut_q, ledOut_d;

  logic                ctrlWrite, dutyWrite, periodWrite, clear, tick;
  logic [DUTY_W-1:0]   activeDuty;
  logic [7:0]          statusTop, ledByte;
  logic                unusedInputs;

  assign ctrlWrite    = chipselect && !write_n && (address == ADDR_CTRL);
  assign dutyWrite    = chipselect && !write_n && (address == ADDR_DUTY);
  assign periodWrite  = chipselect && !write_n && (address == ADDR_PERIOD);
  assign clear        = ctrlWrite || periodWrite;
  assign unusedInputs = &{1'b0, read_n, writedata};
  assign led_out      = ledOut_q;

  led_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .period_i (period_q),
    .clear_i  (clear),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      mode_q     <= MODE_PASS;
      duty_q     <= DUTY_W'(DUTY_RESET);
      period_q   <= PERIOD_W'(PERIOD_RESET);
      phase_q    <= 1'b0;
      pwmCnt_q   <= '0;
      chasePos_q <= NUM_LEDS'(1);
      ledOut_q   <= '0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      pwmCnt_q   <= pwmCnt_d;
      chasePos_q <= chasePos_d;
      ledOut_q   <= ledOut_d;
    end
  end

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    duty_d     = duty_q;
    period_d   = period_q;
    phase_d    = phase_q;
    pwmCnt_d   = pwmCnt_q + DUTY_W'(1);
    chasePos_d = chasePos_q;
    ledOut_d   = led_req;

    if (ctrlWrite) begin
      enable_d = writedata[0];
      mode_d   = mode_e'(writedata[2:1]);
    end
    if (dutyWrite)   duty_d   = writedata[DUTY_W-1:0];
    if (periodWrite) period_d = writedata[PERIOD_W-1:0];

    if (tick) begin
      phase_d    = !phase_q;
      chasePos_d = {chasePos_q[NUM_LEDS-2:0], chasePos_q[NUM_LEDS-1]};
    end
    // Config writes restart the effect from a known point, overriding any tick.
    if (clear) begin
      phase_d    = 1'b0;
      pwmCnt_d   = '0;
      chasePos_d = NUM_LEDS'(1);
    end

    if (enable_q) begin
      case (mode_q)
        MODE_PASS:  ledOut_d = led_req;
        MODE_BLINK: ledOut_d = phase_q ? led_req : '0;
        MODE_PWM:   ledOut_d = (pwmCnt_q < activeDuty) ? led_req : '0;
        MODE_CHASE: ledOut_d = led_req & chasePos_q;
      endcase
    end
  end

`ifdef LED_BREATHE_EN
  logic [DUTY_W-1:0] effDuty_q, effDuty_d;
  logic              effDown_q, effDown_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      effDuty_q <= '0;
      effDown_q <= 1'b0;
    end else begin
      effDuty_q <= effDuty_d;
      effDown_q <= effDown_d;
    end
  end

  // Triangle ramp between 0 and DUTY, turning around at each end without a hold.
  always_comb begin
    effDuty_d = effDuty_q;
    effDown_d = effDown_q;
    if (clear) begin
      effDuty_d = '0;
      effDown_d = 1'b0;
    end else if (dutyWrite && (writedata[DUTY_W-1:0] < effDuty_q)) begin
      effDuty_d = writedata[DUTY_W-1:0];
      effDown_d = 1'b1;
    end else if (tick) begin
      if (!effDown_q) begin
        if (effDuty_q < duty_q) begin
          effDuty_d = effDuty_q + DUTY_W'(1);
        end else begin
          effDown_d = 1'b1;
          if (effDuty_q != '0) effDuty_d = effDuty_q - DUTY_W'(1);
        end
      end else begin
        if (effDuty_q != '0) begin
          effDuty_d = effDuty_q - DUTY_W'(1);
        end else begin
          effDown_d = 1'b0;
          if (duty_q != '0) effDuty_d = effDuty_q + DUTY_W'(1);
        end
      end
    end
  end

  assign activeDuty = effDuty_q;
  assign statusTop  = 8'(effDuty_q);
`else
  assign activeDuty = duty_q;
  assign statusTop  = 8'b0;
`endif

  always_comb begin
    ledByte = '0;
    ledByte[NUM_LEDS-1:0] = ledOut_q;
    readdata = 32'b0;
    case (address)
      ADDR_CTRL:   readdata = {29'b0, mode_q, enable_q};
      ADDR_DUTY:   readdata = 32'(duty_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_STATUS: readdata = {statusTop, 7'b0, phase_q, 8'b0, ledByte};
    endcase
  end

endmodule

// File: tb/tb_led_effect_driver.sv
// Randomised scoreboard bench for led_effect_driver (default build, breathe disabled).
// The driver pushes predicted led_out/readdata per cycle; a negedge monitor compares.
module tb_led_effect_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  led_req;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  led;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];

  // Behavioural model state: chase position kept as a bit index.
  bit         mEn, mPhase;
  int         mMode, mDuty, mPeriod, mPresc, mPwm, mIdx;
  logic [7:0] mLed;

  always #5 clk = ~clk;

  led_effect_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_req    (led_req),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mEn = 0; mMode = 0; mDuty = 128; mPeriod = 25000000;
    mPresc = 0; mPhase = 0; mPwm = 0; mIdx = 0; mLed = 8'h00;
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(mMode * 2 + int'(mEn));
      2'd1:    return 32'(mDuty);
      2'd2:    return 32'(mPeriod);
      default: return (32'(mPhase) << 16) | 32'(mLed);
    endcase
  endfunction

  task automatic modelStep(input logic [7:0] req, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    int         effP;
    bit         tick, clr;
    logic [7:0] nxt;
    effP = (mPeriod == 0) ? 1 : mPeriod;
    tick = (mPresc == effP - 1);
    case (mMode)
      1:       nxt = mPhase ? req : 8'h00;
      2:       nxt = (mPwm < mDuty) ? req : 8'h00;
      3:       nxt = req & (8'h01 << mIdx);
      default: nxt = req;
    endcase
    if (!mEn) nxt = req;
    clr = wr && (a == 2'd0 || a == 2'd2);
    mPresc = (clr || tick) ? 0 : mPresc + 1;
    mPhase = clr ? 1'b0 : (tick ? !mPhase : mPhase);
    mPwm   = clr ? 0 : (mPwm + 1) % 256;
    mIdx   = clr ? 0 : (tick ? (mIdx + 1) % 8 : mIdx);
    if (wr && a == 2'd0) begin mEn = wd[0]; mMode = int'(wd[2:1]); end
    if (wr && a == 2'd1) mDuty = int'(wd[7:0]);
    if (wr && a == 2'd2) mPeriod = int'(wd[25:0]);
    mLed = nxt;
  endtask

  // Drive one cycle's inputs, record the prediction, then advance to just after the edge.
  task automatic applyStimulus(input logic [7:0] req, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    led_req    = req;
    chipselect = wr ? 1'b1 : 1'($urandom_range(0, 1));
    write_n    = !wr;
    read_n     = 1'($urandom_range(0, 1));
    address    = a;
    writedata  = wd;
    e.led = mLed;
    e.rd  = modelRead(a);
    sbq.push_back(e);
    modelStep(req, wr, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] req, input logic [1:0] a);
    for (int i = 0; i < n; i++) applyStimulus(req, 1'b0, a, $urandom);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checkOutput("led_out", {24'b0, led_out}, {24'b0, e.led});
      checkOutput("readdata", readdata, e.rd);
    end
  end

  initial begin
    reset_n = 1'b0; led_req = 8'h00; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; read_n = 1'b1; writedata = 32'h0;
    modelReset();
    #12;
    checkOutput("reset led_out", {24'b0, led_out}, 32'h0);
    address = 2'd0; #1 checkOutput("reset CTRL", readdata, 32'h0);
    address = 2'd1; #1 checkOutput("reset DUTY", readdata, 32'h80);
    address = 2'd2; #1 checkOutput("reset PERIOD", readdata, 32'd25000000);
    address = 2'd3; #1 checkOutput("reset STATUS", readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    idle(4, 8'hA5, 2'd3);

    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd4);
    applyStimulus(8'hFF, 1'b1, 2'd0, 32'd3);
    idle(24, 8'hFF, 2'd3);

    applyStimulus(8'h0F, 1'b1, 2'd0, 32'd5);
    applyStimulus(8'h0F, 1'b1, 2'd1, 32'd64);
    idle(260, 8'h0F, 2'd3);
    applyStimulus(8'h0F, 1'b1, 2'd1, 32'd0);
    idle(260, 8'h0F, 2'd1);
    applyStimulus(8'h0F, 1'b1, 2'd1, 32'd255);
    idle(260, 8'h0F, 2'd3);

    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd1);
    applyStimulus(8'hFF, 1'b1, 2'd0, 32'd7);
    idle(12, 8'hFF, 2'd3);
    idle(12, 8'h0F, 2'd3);

    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd0);
    idle(6, 8'hFF, 2'd3);
    applyStimulus(8'hFF, 1'b1, 2'd0, 32'd3);
    idle(6, 8'hFF, 2'd3);
    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd2);
    idle(1, 8'hFF, 2'd3);
    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd2);
    idle(5, 8'hFF, 2'd3);

    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    wd = 32'($urandom_range(0, 7));
        2'd1:    wd = 32'($urandom_range(0, 255));
        2'd2:    wd = 32'($urandom_range(0, 6));
        default: wd = $urandom;
      endcase
      applyStimulus(8'($urandom), ($urandom_range(0, 7) == 0), a, wd);
    end

    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd1);
    applyStimulus(8'hFF, 1'b1, 2'd0, 32'd7);
    idle(5, 8'hFF, 2'd3);
    reset_n = 1'b0;
    address = 2'd0;
    modelReset();
    #1;
    checkOutput("async reset led_out", {24'b0, led_out}, 32'h0);
    checkOutput("async reset CTRL", readdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3, 8'h3C, 2'd0);
    applyStimulus(8'hFF, 1'b1, 2'd2, 32'd1);
    applyStimulus(8'hFF, 1'b1, 2'd0, 32'd7);
    idle(10, 8'hFF, 2'd3);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
